d_register_pipe: RTL and testbench



---
 rtl/d_register_pipe.sv | 83 ++++++++
 tb/tb_d_register_pipe.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/d_register_pipe.sv
// d_register_pipe: WIDTH-bit, DEPTH-stage D-register delay line with per-stage valid,
// stall, flush and occupancy count. Define D_REGISTER_PIPE_TAPS_EN to expose taps/tap_valid.
module d_register_pipe #(
    parameter int                 WIDTH       = 8,
    parameter int                 DEPTH       = 4,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}},
    parameter int                 CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       d,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       qbar,
    output logic                   out_valid,
`ifdef D_REGISTER_PIPE_TAPS_EN
    output logic [WIDTH*DEPTH-1:0] taps,
    output logic [DEPTH-1:0]       tap_valid,
`endif
    output logic [CNT_W-1:0]       count
);

    logic [DEPTH-1:0][WIDTH-1:0] stage;
    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0]            vld_nxt;
    logic [CNT_W-1:0]            cnt;
    logic [CNT_W-1:0]            cnt_nxt;

    // Next valid vector (flush beats shift) and its population count
    always_comb begin
        vld_nxt = vld;
        if (flush) begin
            vld_nxt = '0;
        end else if (en) begin
            vld_nxt[0] = in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                vld_nxt[i] = vld[i-1];
            end
        end
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(vld_nxt[i]);
        end
    end

    // Data stages: shift on enable regardless of flush or in_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RESET_VALUE;
            end
        end else if (en) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // Valid tags and occupancy count share the same next-state vector
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            cnt <= '0;
        end else begin
            vld <= vld_nxt;
            cnt <= cnt_nxt;
        end
    end

    assign q         = stage[DEPTH-1];
    assign qbar      = ~q;
    assign out_valid = vld[DEPTH-1];
    assign count     = cnt;

`ifdef D_REGISTER_PIPE_TAPS_EN
    assign taps      = stage;
    assign tap_valid = vld;
`endif

endmodule

// File: tb/tb_d_register_pipe.sv
// tb_d_register_pipe: directed + randomized check of d_register_pipe
// against a history-queue reference model (DEPTH=4 and DEPTH=1 instances).
module tb_d_register_pipe;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] dat;
        logic       v;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] d = 8'h00;
    logic [7:0] q, qbar;
    logic       out_valid;
    logic [2:0] count;
    logic       d1 = 1'b0;
    logic       q1, qbar1, ov1;
    logic       count1;
`ifdef D_REGISTER_PIPE_TAPS_EN
    logic [31:0] taps;
    logic [3:0]  tap_valid;
    logic        taps1;
    logic        tap_valid1;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    ent_t hist[$];
    logic h1d;
    logic h1v;

    always #5 clk = ~clk;

    d_register_pipe #(
        .WIDTH(8), .DEPTH(DEPTH), .RESET_VALUE(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .d(d), .q(q), .qbar(qbar),
        .out_valid(out_valid),
`ifdef D_REGISTER_PIPE_TAPS_EN
        .taps(taps), .tap_valid(tap_valid),
`endif
        .count(count)
    );

    d_register_pipe #(
        .WIDTH(1), .DEPTH(1)
    ) dut1 (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .d(d1), .q(q1), .qbar(qbar1),
        .out_valid(ov1),
`ifdef D_REGISTER_PIPE_TAPS_EN
        .taps(taps1), .tap_valid(tap_valid1),
`endif
        .count(count1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, compare #1 after the edge
    task automatic step(input logic r, input logic e, input logic f,
                        input logic iv, input logic [7:0] dd,
                        input logic dv1);
        int         c;
        logic [7:0] eqb;
        logic       eqb1;
        rst = r; en = e; flush = f; in_valid = iv; d = dd; d1 = dv1;
        @(posedge clk);
        if (r) begin
            hist.delete();
            for (int i = 0; i < DEPTH; i++) hist.push_back('{8'hA5, 1'b0});
            h1d = 1'b0;
            h1v = 1'b0;
        end else begin
            if (f) begin
                foreach (hist[i]) hist[i].v = 1'b0;
                h1v = 1'b0;
            end
            if (e) begin
                hist.push_back('{dd, iv & ~f});
                void'(hist.pop_front());
                h1d = dv1;
                h1v = iv & ~f;
            end
        end
        #1;
        c = 0;
        foreach (hist[i]) c += int'(hist[i].v);
        eqb  = ~hist[0].dat;
        eqb1 = ~h1d;
        chk("q", 32'(q), 32'(hist[0].dat));
        chk("qbar", 32'(qbar), 32'(eqb));
        chk("out_valid", 32'(out_valid), 32'(hist[0].v));
        chk("count", 32'(count), 32'(c));
        chk("q1", 32'(q1), 32'(h1d));
        chk("qbar1", 32'(qbar1), 32'(eqb1));
        chk("ov1", 32'(ov1), 32'(h1v));
        chk("count1", 32'(count1), 32'(h1v));
`ifdef D_REGISTER_PIPE_TAPS_EN
        for (int i = 0; i < DEPTH; i++) begin
            chk("taps", 32'(taps[i*8 +: 8]), 32'(hist[DEPTH-1-i].dat));
            chk("tap_valid", 32'(tap_valid[i]), 32'(hist[DEPTH-1-i].v));
        end
        chk("taps1", 32'(taps1), 32'(h1d));
        chk("tap_valid1", 32'(tap_valid1), 32'(h1v));
`endif
    endtask

    initial begin
        // reset
        step(1, 0, 0, 0, 8'h00, 0);
        chk("rst_q", 32'(q), 32'h0000_00A5);
        chk("rst_qbar", 32'(qbar), 32'h0000_005A);
        chk("rst_ov", 32'(out_valid), 32'h0);
        chk("rst_cnt", 32'(count), 32'h0);

        // streaming 01..05
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 0, 1, 8'(i), 1'(i));
            if (i == 4) chk("stream_first", 32'(q), 32'h01);
        end
        chk("stream_cnt", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 8'h06 + 8'(i), 1'(i));

        // stall: 10,11 then 3 held edges then 12,13 and drain
        step(1, 0, 0, 0, 8'h00, 0);
        step(0, 1, 0, 1, 8'h10, 1);
        step(0, 1, 0, 1, 8'h11, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'hEE, 1);
        step(0, 1, 0, 1, 8'h12, 1);
        step(0, 1, 0, 1, 8'h13, 0);
        chk("stall_q10", 32'(q), 32'h10);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'h00, 0);

        // bubble 1,0,1,0 with C0..C3
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1'(~i[0]), 8'hC0 + 8'(i), 0);
        chk("bubble_cnt", 32'(count), 32'd2);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'h00, 1);

        // flush vs in_valid on a full pipe
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 8'h50 + 8'(i), 1);
        chk("full_cnt", 32'(count), 32'd4);
        step(0, 1, 1, 1, 8'h60, 0);
        chk("flush_cnt", 32'(count), 32'd0);
        chk("flush_ov", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'h61 + 8'(i), 1);
        step(0, 1, 0, 1, 8'h70, 1);
        step(1, 1, 1, 1, 8'h71, 1);
        chk("rstflush_q", 32'(q), 32'h0000_00A5);

        // DEPTH=1 toggle 0,1,1,0
        step(0, 1, 0, 1, 8'h00, 0);
        step(0, 1, 0, 1, 8'h00, 1);
        chk("d1_q", 32'(q1), 32'h1);
        step(0, 1, 0, 1, 8'h00, 1);
        step(0, 1, 0, 1, 8'h00, 0);
        chk("d1_q0", 32'(q1), 32'h0);

        // randomized
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 2),
                 1'($urandom_range(0, 99) < 75),
                 1'($urandom_range(0, 99) < 5),
                 1'($urandom),
                 8'($urandom),
                 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
